// File: rtl/writeback_buffer.sv
// Register-file write master: queues datapath results in a small FIFO, retires one
// per cycle onto the write port, and offers youngest-first bypass for two read queries.
module writeback_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_reg,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        rf_stall,
    output logic                        write_enable,
    output logic [ADDR_W-1:0]           write_reg,
    output logic [DATA_W-1:0]           write_data,
    input  logic [ADDR_W-1:0]           lookup_reg_1,
    input  logic [ADDR_W-1:0]           lookup_reg_2,
    output logic                        byp_hit_1,
    output logic [DATA_W-1:0]           byp_data_1,
    output logic                        byp_hit_2,
    output logic [DATA_W-1:0]           byp_data_2,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // No pass-through: a full buffer refuses input even on a retiring edge.
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign in_ready = !w_full;
    assign w_accept = in_valid && !w_full;
    assign w_push   = w_accept && (in_reg != '0);
    assign w_pop    = (r_count != '0) && !rf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_wreg   <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_wreg          <= r_reg[r_rd_ptr];
                r_wdata         <= r_data[r_rd_ptr];
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_reg[r_wr_ptr]  <= in_reg;
                r_data[r_wr_ptr] <= in_data;
                r_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so later matches override: output stage, then FIFO from head.
    function automatic logic [DATA_W:0] bypass(input logic [ADDR_W-1:0] q);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (q != '0) begin
            if (r_we && (r_wreg == q)) res = {1'b1, r_wdata};
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = r_rd_ptr + PTR_W'(i);
                if (r_vld[idx] && (r_reg[idx] == q)) res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    logic [DATA_W:0] w_byp_1;
    logic [DATA_W:0] w_byp_2;

    always_comb begin
        w_byp_1 = bypass(lookup_reg_1);
        w_byp_2 = bypass(lookup_reg_2);
    end

    assign byp_hit_1    = w_byp_1[DATA_W];
    assign byp_data_1   = w_byp_1[DATA_W-1:0];
    assign byp_hit_2    = w_byp_2[DATA_W];
    assign byp_data_2   = w_byp_2[DATA_W-1:0];
    assign write_enable = r_we;
    assign write_reg    = r_wreg;
    assign write_data   = r_wdata;
    assign count        = r_count;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: hand-computed expectations checked with immediate assertions.
module tb_writeback_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        rf_stall;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  lookup_reg_1;
    logic [4:0]  lookup_reg_2;
    logic        byp_hit_1;
    logic [31:0] byp_data_1;
    logic        byp_hit_2;
    logic [31:0] byp_data_2;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    writeback_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .rf_stall(rf_stall),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .lookup_reg_1(lookup_reg_1), .lookup_reg_2(lookup_reg_2),
        .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
        .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; rf_stall = 1'b0; lookup_reg_1 = '0; lookup_reg_2 = '0;
        offer(1'b0, 5'd0, 32'd0);
        #12;
        check("rst_count", count, 0);
        check("rst_we", write_enable, 0);
        check("rst_wreg", write_reg, 0);
        check("rst_wdata", write_data, 0);
        check("rst_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;

        // single write
        offer(1'b1, 5'd8, 32'h0000_00AA);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        check("single_cnt1", count, 1);
        check("single_we0", write_enable, 0);
        tick();
        check("single_we", write_enable, 1);
        check("single_reg", write_reg, 8);
        check("single_data", write_data, 32'hAA);
        check("single_cnt0", count, 0);
        tick();
        check("single_we_drop", write_enable, 0);

        // $zero destination is accepted but discarded
        offer(1'b1, 5'd0, 32'hFFFF_FFFF);
        check("zero_ready", in_ready, 1);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        check("zero_cnt", count, 0);
        tick();
        check("zero_we", write_enable, 0);

        // full / backpressure under stall
        rf_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(1'b1, 5'(10 + k), 32'(100 + k));
            check($sformatf("full_ready%0d", k), in_ready, (k < 4) ? 1 : 0);
            tick();
        end
        offer(1'b0, 5'd0, 32'd0);
        check("full_cnt", count, 4);
        check("full_ready", in_ready, 0);
        check("full_we", write_enable, 0);
        lookup_reg_1 = 5'd12;
        #1;
        check("full_byp_hit", byp_hit_1, 1);
        check("full_byp_data", byp_data_1, 102);
        lookup_reg_1 = 5'd0;
        rf_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drain_we%0d", k), write_enable, 1);
            check($sformatf("drain_reg%0d", k), write_reg, 10 + k);
            check($sformatf("drain_data%0d", k), write_data, 100 + k);
            check($sformatf("drain_cnt%0d", k), count, 3 - k);
        end
        tick();
        check("drain_idle", write_enable, 0);

        // streaming with wrap: one-cycle latency, count stays at 1
        for (int k = 0; k < 10; k++) begin
            offer(1'b1, 5'(k + 1), 32'h1000 + 32'(k));
            tick();
            check($sformatf("strm_cnt%0d", k), count, 1);
            if (k >= 1) begin
                check($sformatf("strm_reg%0d", k), write_reg, k);
                check($sformatf("strm_data%0d", k), write_data, 32'h1000 + 32'(k - 1));
            end
            check($sformatf("strm_we%0d", k), write_enable, (k >= 1) ? 1 : 0);
        end
        offer(1'b0, 5'd0, 32'd0);
        tick();
        check("strm_last_we", write_enable, 1);
        check("strm_last_reg", write_reg, 10);
        check("strm_last_data", write_data, 32'h1009);
        check("strm_cnt_end", count, 0);
        tick();
        check("strm_idle", write_enable, 0);

        // bypass: youngest wins, r0 never hits
        rf_stall = 1'b1; lookup_reg_1 = 5'd3; lookup_reg_2 = 5'd0;
        offer(1'b1, 5'd3, 32'd1);
        tick();
        check("byp_first", byp_data_1, 1);
        offer(1'b1, 5'd3, 32'd2);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        check("byp_hit", byp_hit_1, 1);
        check("byp_young", byp_data_1, 2);
        check("byp_zero_hit", byp_hit_2, 0);
        check("byp_zero_data", byp_data_2, 0);
        lookup_reg_2 = 5'd4;
        #1;
        check("byp_miss", byp_hit_2, 0);
        rf_stall = 1'b0;
        tick();
        check("byp_ret1_we", write_enable, 1);
        check("byp_ret1_data", byp_data_1, 2);
        tick();
        check("byp_outstage_hit", byp_hit_1, 1);
        check("byp_outstage_data", byp_data_1, 2);
        tick();
        check("byp_clear_hit", byp_hit_1, 0);
        check("byp_clear_data", byp_data_1, 0);

        // asynchronous reset mid-drain
        rf_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 5'(20 + k), 32'(k));
            tick();
        end
        offer(1'b0, 5'd0, 32'd0);
        rf_stall = 1'b0;
        tick();
        check("mid_we", write_enable, 1);
        check("mid_cnt", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we", write_enable, 0);
        check("async_cnt", count, 0);
        check("async_ready", in_ready, 1);
        check("async_byp", byp_hit_1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_we", write_enable, 0);
        check("post_rst_cnt", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
